// File: rtl/ic_refill_if.sv
// Bundles the I-cache miss/replacement signals and the L2 memory read port.
// master = refill streamer, slave = cache + memory environment.
interface ic_refill_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  ic_miss_i;
    logic [ADDR_WIDTH-1:0] ic_miss_addr_i;
    logic                  ic_repl_grant_o;
    logic [63:0]           rep_word_o;
    logic                  mem_req_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic                  mem_ready_i;
    logic                  mem_rvalid_i;
    logic [63:0]           mem_rdata_i;
    logic                  busy_o;

    modport master (
        input  ic_miss_i, ic_miss_addr_i, mem_ready_i, mem_rvalid_i, mem_rdata_i,
        output ic_repl_grant_o, rep_word_o, mem_req_o, mem_addr_o, busy_o
    );

    modport slave (
        output ic_miss_i, ic_miss_addr_i, mem_ready_i, mem_rvalid_i, mem_rdata_i,
        input  ic_repl_grant_o, rep_word_o, mem_req_o, mem_addr_o, busy_o
    );
endinterface

// File: rtl/ic_refill_streamer.sv
// I-cache refill engine: fetches a B-byte block into a line buffer, then streams it as B/8 beats.
// Optional IC_REFILL_PERF_EN adds refill and busy-cycle performance counters.
module ic_refill_streamer #(
    parameter int B          = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic        clk_i,
    input  logic        reset_i,
    ic_refill_if.master bus
`ifdef IC_REFILL_PERF_EN
    ,
    output logic [31:0] perf_refills_o,
    output logic [31:0] perf_stall_cycles_o
`endif
);
    localparam int BEATS = B / 8;
    localparam int IDX_W = $clog2(BEATS);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {IDLE, FETCH, STREAM, COOL} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  base_q;
    logic [CNT_W-1:0]       issue_cnt_q, recv_cnt_q;
    logic [IDX_W-1:0]       stream_cnt_q;
    logic                   grant_q;
    logic [63:0]            rep_word_q;
    logic [BEATS-1:0][63:0] line_q;

    logic mem_accept, last_rx, last_beat;

    assign bus.mem_req_o       = (state_q == FETCH) && (issue_cnt_q < CNT_W'(BEATS));
    assign bus.mem_addr_o      = base_q + (ADDR_WIDTH'(issue_cnt_q) << 3);
    assign bus.busy_o          = (state_q != IDLE);
    assign bus.ic_repl_grant_o = grant_q;
    assign bus.rep_word_o      = rep_word_q;

    assign mem_accept = bus.mem_req_o && bus.mem_ready_i;
    assign last_rx    = (state_q == FETCH) && bus.mem_rvalid_i && (recv_cnt_q == CNT_W'(BEATS - 1));
    assign last_beat  = (stream_cnt_q == IDX_W'(BEATS - 1));

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Miss is rechecked only when the fetch has fully drained, so no read is left outstanding.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.ic_miss_i) state_d = FETCH;
            FETCH:   if (last_rx) state_d = bus.ic_miss_i ? STREAM : IDLE;
            STREAM:  if (last_beat) state_d = COOL;
            COOL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            base_q       <= '0;
            issue_cnt_q  <= '0;
            recv_cnt_q   <= '0;
            stream_cnt_q <= '0;
            grant_q      <= 1'b0;
            rep_word_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.ic_miss_i) begin
                        base_q      <= bus.ic_miss_addr_i & ~ADDR_WIDTH'(B - 1);
                        issue_cnt_q <= '0;
                        recv_cnt_q  <= '0;
                    end
                end
                FETCH: begin
                    if (mem_accept)       issue_cnt_q <= issue_cnt_q + CNT_W'(1);
                    if (bus.mem_rvalid_i) recv_cnt_q  <= recv_cnt_q + CNT_W'(1);
                    // Beat 0 landed earlier, so it can be preloaded while the last beat is written.
                    if (state_d == STREAM) begin
                        grant_q      <= 1'b1;
                        rep_word_q   <= line_q[0];
                        stream_cnt_q <= '0;
                    end
                end
                STREAM: begin
                    stream_cnt_q <= stream_cnt_q + IDX_W'(1);
                    if (last_beat) begin
                        grant_q    <= 1'b0;
                        rep_word_q <= '0;
                    end else begin
                        rep_word_q <= line_q[stream_cnt_q + IDX_W'(1)];
                    end
                end
                default: ;
            endcase
        end
    end

    // Line buffer holds no state that matters across reset.
    always_ff @(posedge clk_i) begin
        if (state_q == FETCH && bus.mem_rvalid_i)
            line_q[recv_cnt_q[IDX_W-1:0]] <= bus.mem_rdata_i;
    end

`ifdef IC_REFILL_PERF_EN
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            perf_refills_o      <= '0;
            perf_stall_cycles_o <= '0;
        end else begin
            if (state_q == FETCH && state_d == STREAM) perf_refills_o <= perf_refills_o + 32'd1;
            if (state_q != IDLE) perf_stall_cycles_o <= perf_stall_cycles_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ic_refill_streamer.sv
// Randomized bench for ic_refill_streamer: an in-order memory model with configurable
// readiness/latency and a block-level expectation of addresses, beats and timing.
module tb_ic_refill_streamer;
    localparam int B     = 64;
    localparam int BEATS = B / 8;
    localparam int AW    = 32;

    logic clk_i   = 1'b0;
    logic reset_i = 1'b0;
    always #5 clk_i = ~clk_i;

    ic_refill_if #(.ADDR_WIDTH(AW)) bus ();

`ifdef IC_REFILL_PERF_EN
    logic [31:0] perf_refills, perf_stall;
`endif

    ic_refill_streamer #(.B(B), .ADDR_WIDTH(AW)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
`ifdef IC_REFILL_PERF_EN
        ,
        .perf_refills_o      (perf_refills),
        .perf_stall_cycles_o (perf_stall)
`endif
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int ready_mode = 0;
    int lat = 1;
    logic [31:0] seed = 32'h1357_9bdf;

    typedef struct { logic [31:0] addr; int due; } rd_t;
    rd_t pend[$];

    function automatic logic [63:0] mdata(input logic [31:0] a);
        return {a ^ seed, (a * 32'h9E37_79B1) ^ ~seed};
    endfunction

    always @(posedge clk_i) cyc++;

    // Memory model: ready pattern and in-order responses due lat cycles after accept.
    always @(posedge clk_i) begin
        #1;
        case (ready_mode)
            0:       bus.mem_ready_i = 1'b1;
            1:       bus.mem_ready_i = cyc[0];
            default: bus.mem_ready_i = ($urandom_range(0, 3) != 0);
        endcase
        if (reset_i && pend.size() > 0 && pend[0].due <= cyc) begin
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rdata_i  = mdata(pend[0].addr);
        end else begin
            bus.mem_rvalid_i = 1'b0;
            bus.mem_rdata_i  = {$urandom, $urandom};
        end
    end

    always @(negedge clk_i) begin
        if (!reset_i) pend.delete();
        else begin
            if (bus.mem_rvalid_i) void'(pend.pop_front());
            if (bus.mem_req_o && bus.mem_ready_i) pend.push_back('{bus.mem_addr_o, cyc + lat});
        end
    end

    // One refill seen from the cache: miss held until the first idle cycle after the block.
    task automatic refill(input logic [31:0] a, input int drop_k, input bit keep_miss,
                          input logic [31:0] next_a, input bit predriven, input int exp_lat,
                          input string tag);
        logic [31:0] base, exp_w;
        int start, acc_n, beat_n, rv_n, last_rv, g_first, g_last, end_cyc;
        bit done, cool_seen, gap;
        base = a & ~32'(B - 1);
        acc_n = 0; beat_n = 0; rv_n = 0; last_rv = -1; g_first = -1; g_last = -1;
        end_cyc = -1; done = 0; cool_seen = 0; gap = 0;
        if (!predriven) begin
            @(posedge clk_i); #2;
            bus.ic_miss_i = 1'b1;
            bus.ic_miss_addr_i = a;
        end
        start = cyc;
        for (int k = 1; k <= 300 && !done; k++) begin
            @(posedge clk_i); #2;
            if (drop_k > 0 && k == drop_k) bus.ic_miss_i = 1'b0;
            if (bus.mem_req_o && bus.mem_ready_i) begin
                exp_w = base + 32'(8 * acc_n);
                tests++;
                if (bus.mem_addr_o !== exp_w) begin
                    fails++;
                    $display("FAIL %s req_addr[%0d]: got %h expected %h", tag, acc_n, bus.mem_addr_o, exp_w);
                end
                acc_n++;
            end
            if (bus.mem_rvalid_i) begin rv_n++; last_rv = cyc; end
            if (g_last >= 0 && cyc == g_last + 1 && bus.busy_o && !bus.ic_repl_grant_o) cool_seen = 1;
            if (bus.ic_repl_grant_o) begin
                tests++;
                if (bus.rep_word_o !== mdata(base + 32'(8 * beat_n))) begin
                    fails++;
                    $display("FAIL %s beat[%0d]: got %h expected %h", tag, beat_n, bus.rep_word_o,
                             mdata(base + 32'(8 * beat_n)));
                end
                if (g_first < 0) g_first = cyc;
                else if (cyc != g_last + 1) gap = 1;
                g_last = cyc;
                beat_n++;
            end
            if (!bus.busy_o) begin
                done = 1;
                end_cyc = cyc;
                if (keep_miss) bus.ic_miss_addr_i = next_a;
                else bus.ic_miss_i = 1'b0;
            end
        end
        tests++;
        if (!done) begin fails++; $display("FAIL %s timeout: busy never fell within 300 cycles", tag); end
        tests++;
        if (acc_n != BEATS) begin fails++; $display("FAIL %s req_count: got %0d expected %0d", tag, acc_n, BEATS); end
        tests++;
        if (rv_n != BEATS) begin fails++; $display("FAIL %s rvalid_count: got %0d expected %0d", tag, rv_n, BEATS); end
        if (drop_k > 0) begin
            tests++;
            if (beat_n != 0) begin fails++; $display("FAIL %s grant_after_drop: got %0d beats expected 0", tag, beat_n); end
            tests++;
            if (end_cyc != last_rv + 1) begin
                fails++; $display("FAIL %s busy_fall: got cycle %0d expected %0d", tag, end_cyc, last_rv + 1);
            end
        end else begin
            tests++;
            if (beat_n != BEATS || gap) begin
                fails++; $display("FAIL %s grant_run: got %0d beats gap=%0d expected %0d contiguous", tag, beat_n, gap, BEATS);
            end
            tests++;
            if (g_first != last_rv + 1) begin
                fails++; $display("FAIL %s first_grant: got cycle %0d expected %0d", tag, g_first, last_rv + 1);
            end
            tests++;
            if (!cool_seen || end_cyc != g_last + 2) begin
                fails++; $display("FAIL %s cool: got cool=%0d idle at %0d expected idle at %0d", tag, cool_seen, end_cyc, g_last + 2);
            end
            if (exp_lat > 0) begin
                tests++;
                if (g_first - start != exp_lat) begin
                    fails++; $display("FAIL %s latency: got %0d expected %0d", tag, g_first - start, exp_lat);
                end
            end
        end
    endtask

    task automatic test_reset;
        reset_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #2;
        tests++; if (bus.ic_repl_grant_o !== 1'b0) begin fails++; $display("FAIL reset grant: got %b expected 0", bus.ic_repl_grant_o); end
        tests++; if (bus.rep_word_o !== 64'd0) begin fails++; $display("FAIL reset rep_word: got %h expected 0", bus.rep_word_o); end
        tests++; if (bus.mem_req_o !== 1'b0) begin fails++; $display("FAIL reset mem_req: got %b expected 0", bus.mem_req_o); end
        tests++; if (bus.mem_addr_o !== 32'd0) begin fails++; $display("FAIL reset mem_addr: got %h expected 0", bus.mem_addr_o); end
        tests++; if (bus.busy_o !== 1'b0) begin fails++; $display("FAIL reset busy: got %b expected 0", bus.busy_o); end
        reset_i = 1'b1;
    endtask

    task automatic test_basic_back_to_back;
        seed = $urandom; ready_mode = 0; lat = 1;
        refill(32'h0000_1234, 0, 1'b1, 32'h0000_4000, 1'b0, 10, "basic");
        refill(32'h0000_4000, 0, 1'b0, 32'h0, 1'b1, 10, "after_cool");
    endtask

    task automatic test_toggle_ready;
        seed = $urandom; ready_mode = 1; lat = 3;
        refill($urandom, 0, 1'b0, 32'h0, 1'b0, 0, "toggle");
    endtask

    task automatic test_miss_drop;
        seed = $urandom; ready_mode = 0; lat = 2;
        refill($urandom, 3, 1'b0, 32'h0, 1'b0, 0, "drop");
    endtask

    task automatic test_random;
        for (int i = 0; i < 4; i++) begin
            seed = $urandom; ready_mode = 2; lat = $urandom_range(1, 4);
            refill($urandom, 0, 1'b0, 32'h0, 1'b0, 0, "random");
        end
    endtask

    task automatic test_reset_mid_stream;
        int n;
        seed = $urandom; ready_mode = 0; lat = 1; n = 0;
        @(posedge clk_i); #2;
        bus.ic_miss_i = 1'b1;
        bus.ic_miss_addr_i = $urandom;
        for (int k = 0; k < 100 && n < 4; k++) begin
            @(posedge clk_i); #2;
            if (bus.ic_repl_grant_o) n++;
        end
        tests++;
        if (n != 4) begin fails++; $display("FAIL midreset reach_beat3: got %0d beats expected 4", n); end
        #1 reset_i = 1'b0;
        #1;
        tests++; if (bus.ic_repl_grant_o !== 1'b0) begin fails++; $display("FAIL midreset grant: got %b expected 0", bus.ic_repl_grant_o); end
        tests++; if (bus.mem_req_o !== 1'b0) begin fails++; $display("FAIL midreset mem_req: got %b expected 0", bus.mem_req_o); end
        tests++; if (bus.busy_o !== 1'b0) begin fails++; $display("FAIL midreset busy: got %b expected 0", bus.busy_o); end
        tests++; if (bus.rep_word_o !== 64'd0) begin fails++; $display("FAIL midreset rep_word: got %h expected 0", bus.rep_word_o); end
        bus.ic_miss_i = 1'b0;
        @(posedge clk_i); #3;
        reset_i = 1'b1;
        refill($urandom, 0, 1'b0, 32'h0, 1'b0, 10, "post_reset");
    endtask

`ifdef IC_REFILL_PERF_EN
    task automatic test_perf;
        @(posedge clk_i); #3 reset_i = 1'b0;
        @(posedge clk_i); #3 reset_i = 1'b1;
        tests++;
        if (perf_refills !== 32'd0 || perf_stall !== 32'd0) begin
            fails++; $display("FAIL perf_reset: got %0d/%0d expected 0/0", perf_refills, perf_stall);
        end
        seed = $urandom; ready_mode = 0; lat = 1;
        refill($urandom, 0, 1'b0, 32'h0, 1'b0, 10, "perf1");
        refill($urandom, 0, 1'b0, 32'h0, 1'b0, 10, "perf2");
        // Each refill: BEATS+1 fetch cycles, BEATS stream cycles, one cool cycle.
        tests++;
        if (perf_refills !== 32'd2) begin fails++; $display("FAIL perf_refills: got %0d expected 2", perf_refills); end
        tests++;
        if (perf_stall !== 32'(2 * (2 * BEATS + 2))) begin
            fails++; $display("FAIL perf_stall: got %0d expected %0d", perf_stall, 2 * (2 * BEATS + 2));
        end
    endtask
`endif

    initial begin
        bus.ic_miss_i      = 1'b0;
        bus.ic_miss_addr_i = '0;
        bus.mem_ready_i    = 1'b0;
        bus.mem_rvalid_i   = 1'b0;
        bus.mem_rdata_i    = '0;
        test_reset();
        test_basic_back_to_back();
        test_toggle_ready();
        test_miss_drop();
        test_random();
        test_reset_mid_stream();
`ifdef IC_REFILL_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
